n_to_binary_scanner: RTL and testbench

Serialising one-hot/multi-hot to binary encoder: accepts an INPUT_WIDTH-bit vector of flagged events and emits the binary index of each set bit, lowest index first, one per output handshake. It is the reverse of the binary-to-N address decoders: it turns per-thread or per-port flag vectors back into binary indices for the I/O predication and event-dispatch logic. The index stream is registered. The block drains one full vector before it accepts the next.

---
 rtl/n_to_binary_scanner_pkg.sv | 26 ++
 rtl/n_to_binary_scanner_lowest_set_bit_encoder.sv | 36 +++
 rtl/n_to_binary_scanner.sv | 145 ++++++++++++++
 tb/tb_n_to_binary_scanner.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n_to_binary_scanner_pkg.sv
// -----------------------------------------------------------------------------
// n_to_binary_scanner_pkg
//   Shared definitions for the flag-vector-to-binary-index scanner.
//   - scan_state_e : two-state FSM encoding (IDLE, SCAN), also used on the
//                    scanner's debug state output.
//   - index_width  : ceiling log2, used at elaboration to make sure the
//                    emitted index is wide enough to name every flag bit.
// -----------------------------------------------------------------------------
package n_to_binary_scanner_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Smallest w with 2**w >= n. Evaluated only at elaboration time.
  function automatic int index_width(input int n);
    int r;
    r = 32;
    for (int w = 31; w >= 0; w--) begin
      if ((longint'(1) << w) >= longint'(n)) r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/n_to_binary_scanner_lowest_set_bit_encoder.sv
// -----------------------------------------------------------------------------
// lowest_set_bit_encoder
//   Purely combinational helper for n_to_binary_scanner. Looks at the pending
//   flag vector and reports which bit the scanner emits next.
//   Ports:
//     pending    in  INPUT_WIDTH   flags still waiting to be emitted
//     index      out BINARY_WIDTH  index of the lowest set bit (0 if none)
//     clear_mask out INPUT_WIDTH   one-hot mask of that lowest set bit
//     single     out 1             exactly one bit of pending is set
// -----------------------------------------------------------------------------
module lowest_set_bit_encoder #(
  parameter int INPUT_WIDTH  = 8,
  parameter int BINARY_WIDTH = 3
) (
  input  logic [INPUT_WIDTH-1:0]  pending,
  output logic [BINARY_WIDTH-1:0] index,
  output logic [INPUT_WIDTH-1:0]  clear_mask,
  output logic                    single
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    index = '0;
    for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) index = BINARY_WIDTH'(i);
    end
  end

  // x & -x isolates the lowest set bit.
  assign clear_mask = pending & (~pending + INPUT_WIDTH'(1));

  // x & (x-1) clears the lowest set bit; zero result means at most one was set.
  assign single = (pending != '0) &&
                  ((pending & (pending - INPUT_WIDTH'(1))) == '0);

endmodule

// File: rtl/n_to_binary_scanner.sv
// -----------------------------------------------------------------------------
// n_to_binary_scanner
//   Serialising multi-hot to binary encoder. Accepts an INPUT_WIDTH-bit flag
//   vector and emits the binary index of every set bit, lowest first, one per
//   output handshake. A whole vector is drained before the next is accepted;
//   the last beat of a vector can overlap the acceptance of the next one, so
//   back-to-back vectors stream without a bubble.
//
//   Handshake: a transfer happens on a rising clock edge where valid and ready
//   are both high. The producer holds in_valid and in stable until accepted;
//   the scanner holds out/out_last/out_zero stable while out_valid is high and
//   out_ready is low. in_ready depends combinationally on out_ready (last beat
//   only); nothing on the output side depends combinationally on in.
//
//   Ports:
//     clock, reset_n      rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready   input vector handshake
//     in                  flag vector, bit i set = index i pending
//     out_valid/out_ready index stream handshake
//     out                 index of the lowest pending bit
//     out_last            this beat is the final index of the vector
//     out_zero            beat reports an all-zero vector (optional feature)
//     dbg_state           current FSM state, for observation only
//
//   Build option N_TO_BINARY_SCANNER_ZERO_FLAG_EN: when defined, an accepted
//   all-zero vector produces one beat with out=0, out_last=1, out_zero=1.
//   When undefined, all-zero vectors are swallowed and out_zero is 0.
// -----------------------------------------------------------------------------
module n_to_binary_scanner
  import n_to_binary_scanner_pkg::*;
#(
  parameter int INPUT_WIDTH  = 8,
  parameter int BINARY_WIDTH = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BINARY_WIDTH-1:0] out,
  output logic                    out_last,
  output logic                    out_zero,
  output scan_state_e             dbg_state
);

  if (INPUT_WIDTH < 1) begin : g_bad_input_width
    $fatal(1, "n_to_binary_scanner: INPUT_WIDTH must be >= 1");
  end
  if (BINARY_WIDTH < index_width(INPUT_WIDTH)) begin : g_bad_binary_width
    $fatal(1, "n_to_binary_scanner: BINARY_WIDTH too small for INPUT_WIDTH");
  end

  scan_state_e             r_state;
  scan_state_e             w_state_nxt;
  logic [INPUT_WIDTH-1:0]  r_pending;
  logic [INPUT_WIDTH-1:0]  w_pending_nxt;
  logic [BINARY_WIDTH-1:0] w_index;
  logic [INPUT_WIDTH-1:0]  w_clear_mask;
  logic                    w_single;
  logic                    w_zero_beat;
  logic                    w_last;
  logic                    w_accept;

  lowest_set_bit_encoder #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .BINARY_WIDTH (BINARY_WIDTH)
  ) u_lsb (
    .pending    (r_pending),
    .index      (w_index),
    .clear_mask (w_clear_mask),
    .single     (w_single)
  );

`ifdef N_TO_BINARY_SCANNER_ZERO_FLAG_EN
  // Marks a SCAN visit that carries the all-zero report rather than indices.
  logic r_zero;
  logic w_zero_nxt;
  assign w_zero_beat = r_zero;
`else
  assign w_zero_beat = 1'b0;
`endif

  assign w_last   = (r_state == ST_SCAN) && (w_single || w_zero_beat);
  // Ready in IDLE, or on the final beat of a vector when it is being taken.
  assign in_ready = (r_state == ST_IDLE) ||
                    ((r_state == ST_SCAN) && out_ready && w_last);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
`ifdef N_TO_BINARY_SCANNER_ZERO_FLAG_EN
    w_zero_nxt    = r_zero;
`endif
    if ((r_state == ST_SCAN) && out_ready) begin
      w_pending_nxt = r_pending & ~w_clear_mask;
`ifdef N_TO_BINARY_SCANNER_ZERO_FLAG_EN
      w_zero_nxt    = 1'b0;
`endif
      if (w_last) w_state_nxt = ST_IDLE;
    end
    // Acceptance overrides the drain above, which lets the final beat of one
    // vector and the capture of the next share a cycle.
    if (w_accept) begin
      if (in != '0) begin
        w_pending_nxt = in;
        w_state_nxt   = ST_SCAN;
      end
`ifdef N_TO_BINARY_SCANNER_ZERO_FLAG_EN
      else begin
        w_pending_nxt = '0;
        w_zero_nxt    = 1'b1;
        w_state_nxt   = ST_SCAN;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

`ifdef N_TO_BINARY_SCANNER_ZERO_FLAG_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_zero <= 1'b0;
    else          r_zero <= w_zero_nxt;
  end
`endif

  // pending is zero outside SCAN, so out and out_last fall to 0 there.
  assign out_valid = (r_state == ST_SCAN);
  assign out       = w_index;
  assign out_last  = w_last;
  assign out_zero  = w_zero_beat;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_n_to_binary_scanner.sv
module tb_n_to_binary_scanner;
  import n_to_binary_scanner_pkg::*;

  localparam int IW = 8;
  localparam int BW = 3;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- main DUT (8 -> 3) ----------------
  logic          in_valid  = 1'b0;
  logic [IW-1:0] in_vec    = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, out_last, out_zero;
  logic [BW-1:0] out_idx;
  scan_state_e   dbg_state;

  n_to_binary_scanner #(.INPUT_WIDTH(IW), .BINARY_WIDTH(BW)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .dbg_state (dbg_state)
  );

  // ---------------- narrow DUT (5 -> 3) ----------------
  logic       in_valid5  = 1'b0;
  logic [4:0] in_vec5    = '0;
  logic       out_ready5 = 1'b1;
  logic       in_ready5, out_valid5, out_last5, out_zero5;
  logic [2:0] out_idx5;
  scan_state_e dbg_state5;

  n_to_binary_scanner #(.INPUT_WIDTH(5), .BINARY_WIDTH(3)) u_dut5 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .in        (in_vec5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out       (out_idx5),
    .out_last  (out_last5),
    .out_zero  (out_zero5),
    .dbg_state (dbg_state5)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [BW-1:0] exp_q[$];

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, want 0", out_valid);
    end
    n_tests++;
    if (out_idx !== 3'd0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: got out=%0d last=%b, want out=0 last=0", out_idx, out_last);
    end
    n_tests++;
    if (out_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_zero: got %b, want 0", out_zero);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d, want IDLE", dbg_state);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [BW-1:0] exp;
    exp_q.delete();
    exp_q.push_back(3'd2); exp_q.push_back(3'd5); exp_q.push_back(3'd7);
    out_ready = 1'b1;
    in_vec    = 8'b1010_0100;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      exp = exp_q.pop_front();
      n_tests++;
      if (out_valid !== 1'b1 || out_idx !== exp || out_last !== (b == 2) || in_ready !== (b == 2)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got valid=%b out=%0d last=%b in_ready=%b, want valid=1 out=%0d last=%b in_ready=%b",
                 b, out_valid, out_idx, out_last, in_ready, exp, (b == 2), (b == 2));
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_drained: got valid=%b in_ready=%b, want valid=0 in_ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_vec    = 8'b0000_0011;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got valid=%b out=%0d last=%b in_ready=%b, want valid=1 out=0 last=0 in_ready=0",
                 c, out_valid, out_idx, out_last, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL stall_release0: got valid=%b out=%0d last=%b, want valid=1 out=0 last=0", out_valid, out_idx, out_last);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd1 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release1: got valid=%b out=%0d last=%b in_ready=%b, want valid=1 out=1 last=1 in_ready=1",
                         out_valid, out_idx, out_last, in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_drained: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_vec    = 8'h80;
    in_valid  = 1'b1;
    tick();
    // First vector's only beat is showing; offer the next one right away.
    in_vec = 8'h01;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: got valid=%b out=%0d last=%b in_ready=%b, want valid=1 out=7 last=1 in_ready=1",
                         out_valid, out_idx, out_last, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got valid=%b out=%0d last=%b, want valid=1 out=0 last=1", out_valid, out_idx, out_last);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drained: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_zero_vector();
    out_ready = 1'b1;
    in_vec    = 8'h00;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef N_TO_BINARY_SCANNER_ZERO_FLAG_EN
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b1 || out_zero !== 1'b1) begin
      n_fail++; $display("FAIL zero_beat: got valid=%b out=%0d last=%b zero=%b, want valid=1 out=0 last=1 zero=1",
                         out_valid, out_idx, out_last, out_zero);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_zero !== 1'b0) begin
      n_fail++; $display("FAIL zero_after: got valid=%b zero=%b, want valid=0 zero=0", out_valid, out_zero);
    end
`else
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_zero !== 1'b0) begin
      n_fail++; $display("FAIL zero_silent: got valid=%b in_ready=%b zero=%b, want valid=0 in_ready=1 zero=0",
                         out_valid, in_ready, out_zero);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL zero_idle: got valid=%b state=%0d, want valid=0 state=IDLE", out_valid, dbg_state);
    end
`endif
  endtask

  task automatic test_all_ones();
    out_ready = 1'b1;
    in_vec    = 8'hFF;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < IW; b++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_idx !== BW'(b) || out_last !== (b == IW - 1)) begin
        n_fail++; $display("FAIL all_ones_beat%0d: got valid=%b out=%0d last=%b, want valid=1 out=%0d last=%b",
                           b, out_valid, out_idx, out_last, b, (b == IW - 1));
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL all_ones_drained: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    out_ready = 1'b1;
    in_vec    = 8'hFF;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_idx !== BW'(b)) begin
        n_fail++; $display("FAIL midreset_pre%0d: got valid=%b out=%0d, want valid=1 out=%0d", b, out_valid, out_idx, b);
      end
      tick();
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: got valid=%b out=%0d last=%b, want valid=0 out=0 last=0", out_valid, out_idx, out_last);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_released: got valid=%b in_ready=%b, want valid=0 in_ready=1", out_valid, in_ready);
    end
    in_vec   = 8'h10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL midreset_next: got valid=%b out=%0d last=%b, want valid=1 out=4 last=1", out_valid, out_idx, out_last);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_no_leftover: got valid=%b out=%0d, want valid=0", out_valid, out_idx);
    end
  endtask

  task automatic test_width5();
    out_ready5 = 1'b1;
    in_vec5    = 5'b10001;
    in_valid5  = 1'b1;
    tick();
    in_valid5 = 1'b0;
    n_tests++;
    if (out_valid5 !== 1'b1 || out_idx5 !== 3'd0 || out_last5 !== 1'b0) begin
      n_fail++; $display("FAIL w5_beat0: got valid=%b out=%0d last=%b, want valid=1 out=0 last=0", out_valid5, out_idx5, out_last5);
    end
    tick();
    n_tests++;
    if (out_valid5 !== 1'b1 || out_idx5 !== 3'd4 || out_last5 !== 1'b1) begin
      n_fail++; $display("FAIL w5_beat1: got valid=%b out=%0d last=%b, want valid=1 out=4 last=1", out_valid5, out_idx5, out_last5);
    end
    tick();
    n_tests++;
    if (out_valid5 !== 1'b0) begin
      n_fail++; $display("FAIL w5_drained: got valid=%b, want 0", out_valid5);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_zero_vector();
    test_all_ones();
    test_reset_mid_scan();
    test_width5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
